// File: rtl/fetch_stage_if.sv
// Bundle of the instruction-memory request/response channels and the
// decode-side handshake around the fetch stage.
interface fetch_stage_if;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        idValid;
    logic [31:0] idInstruction;
    logic [31:0] idPc;

    modport master (
        output imemReqValid, imemReqAddr, idValid, idInstruction, idPc,
        input  imemReqReady, imemRespValid, imemRespData, stall, redirect, redirectPc
    );

    modport slave (
        input  imemReqValid, imemReqAddr, idValid, idInstruction, idPc,
        output imemReqReady, imemRespValid, imemRespData, stall, redirect, redirectPc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers {pc, instruction} for decode and squashes on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [31:0] fifo_pc_q    [QUEUE_DEPTH];
    logic [31:0] fifo_instr_q [QUEUE_DEPTH];
    logic [31:0] tag_q        [QUEUE_DEPTH];

    logic        req_valid, accept, pop, resp, keep, fifo_nonempty;
    logic [CNT_W-1:0] credit_used;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = bus.redirectPc & ~32'h3;
    assign credit_used   = out_cnt_q + fifo_cnt_q;
    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign req_valid     = !reset && !bus.redirect && (credit_used < DEPTH_C);
    assign accept        = req_valid && bus.imemReqReady;
    assign pop           = fifo_nonempty && !bus.stall && !bus.redirect;
    assign resp          = bus.imemRespValid;
    // Responses landing during a redirect belong to the squashed stream.
    assign keep          = resp && (drop_cnt_q == '0) && !bus.redirect;

    assign bus.imemReqValid  = req_valid;
    assign bus.imemReqAddr   = fetch_pc_q;
    assign bus.idValid       = fifo_nonempty;
    assign bus.idInstruction = fifo_nonempty ? fifo_instr_q[fifo_rd_q] : NOP_INSTRUCTION;
    assign bus.idPc          = fifo_nonempty ? fifo_pc_q[fifo_rd_q] : last_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        last_pc_d  = last_pc_q;
        out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(resp);
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(keep) - CNT_W'(pop);
        fifo_rd_d  = fifo_rd_q + PTR_W'(pop);
        fifo_wr_d  = fifo_wr_q + PTR_W'(keep);
        tag_wr_d   = tag_wr_q + PTR_W'(accept);
        tag_rd_d   = tag_rd_q + PTR_W'(resp);

        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (pop)    last_pc_d  = fifo_pc_q[fifo_rd_q];

        if (bus.redirect) begin
            // Every request still in flight after this edge must be discarded.
            drop_cnt_d = out_cnt_d;
            fifo_cnt_d = '0;
            fifo_rd_d  = fifo_wr_q;
            fetch_pc_d = redirect_pc_aligned;
        end else if (resp && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            last_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            last_pc_q  <= last_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage entries carry no reset; occupancy is tracked by the counters.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (accept && tag_wr_q == PTR_W'(gi)) begin
                    tag_q[gi] <= fetch_pc_q;
                end
                if (keep && fifo_wr_q == PTR_W'(gi)) begin
                    fifo_pc_q[gi]    <= tag_q[tag_rd_q];
                    fifo_instr_q[gi] <= bus.imemRespData;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order memory model with random
// latency plus a queue-based reference of the fetch/decode behaviour.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus_if ();

    fetch_stage #(
        .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH), .NOP_INSTRUCTION(NOP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if)
    );

    typedef struct { logic [31:0] pc; logic drop; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    flight_t     flight_q[$];
    entry_t      buf_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_last_pc;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        flight_q.delete();
        buf_q.delete();
        mem_q.delete();
        m_fetch_pc = RESET_PC;
        m_last_pc  = RESET_PC;
    endtask

    task automatic drive_idle();
        bus_if.imemReqReady  = 1'b0;
        bus_if.imemRespValid = 1'b0;
        bus_if.imemRespData  = 32'h0;
        bus_if.stall         = 1'b0;
        bus_if.redirect      = 1'b0;
        bus_if.redirectPc    = 32'h0;
    endtask

    task automatic run_cycles(input int n, input int p_stall, input int p_redir,
                              input int p_notready, input int max_lat);
        for (int i = 0; i < n; i++) begin
            logic        exp_req, accept, pop, rv;
            logic [31:0] rdata;
            flight_t     f;
            @(negedge clk);
            bus_if.stall        = ($urandom_range(0, 99) < p_stall);
            bus_if.redirect     = ($urandom_range(0, 99) < p_redir);
            bus_if.redirectPc   = {20'h0, 12'($urandom_range(0, 4095))};
            bus_if.imemReqReady = ($urandom_range(0, 99) >= p_notready);
            rv    = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            rdata = rv ? mem_data(mem_q[0].addr) : $urandom;
            bus_if.imemRespValid = rv;
            bus_if.imemRespData  = rdata;
            #1;
            exp_req = !bus_if.redirect && ((flight_q.size() + buf_q.size()) < DEPTH);
            check_val("req_valid", 32'(bus_if.imemReqValid), 32'(exp_req));
            check_val("req_addr", bus_if.imemReqAddr, m_fetch_pc);
            check_val("id_valid", 32'(bus_if.idValid), 32'(buf_q.size() > 0));
            check_val("id_instr", bus_if.idInstruction, (buf_q.size() > 0) ? buf_q[0].instr : NOP);
            check_val("id_pc", bus_if.idPc, (buf_q.size() > 0) ? buf_q[0].pc : m_last_pc);

            accept = exp_req && bus_if.imemReqReady;
            pop    = (buf_q.size() > 0) && !bus_if.stall && !bus_if.redirect;
            if (pop) begin
                m_last_pc = buf_q[0].pc;
                void'(buf_q.pop_front());
            end
            if (rv) begin
                void'(mem_q.pop_front());
                f = flight_q.pop_front();
                if (!f.drop && !bus_if.redirect) buf_q.push_back('{pc: f.pc, instr: rdata});
            end
            if (accept) begin
                flight_q.push_back('{pc: m_fetch_pc, drop: 1'b0});
                mem_q.push_back('{addr: m_fetch_pc, due: cyc + $urandom_range(1, max_lat)});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (bus_if.redirect) begin
                buf_q.delete();
                foreach (flight_q[k]) flight_q[k].drop = 1'b1;
                m_fetch_pc = bus_if.redirectPc & ~32'h3;
            end
            cyc++;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        check_val("rst_req_valid", 32'(bus_if.imemReqValid), 32'h0);
        check_val("rst_id_valid", 32'(bus_if.idValid), 32'h0);
        check_val("rst_id_instr", bus_if.idInstruction, NOP);
        check_val("rst_id_pc", bus_if.idPc, RESET_PC);
        check_val("rst_req_addr", bus_if.imemReqAddr, RESET_PC);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc++;
    endtask

    initial begin
        drive_idle();
        model_reset();
        reset_pulse();
        run_cycles(30, 0, 0, 0, 1);      // clean streaming
        run_cycles(60, 60, 0, 0, 1);     // decode stalls
        run_cycles(60, 10, 0, 50, 3);    // request backpressure
        run_cycles(150, 30, 15, 20, 3);  // redirects mixed with stalls
        run_cycles(12, 100, 0, 0, 1);    // fill the buffer
        reset_pulse();
        run_cycles(20, 0, 0, 0, 1);
        run_cycles(400, 25, 8, 25, 4);   // long random run
        reset_pulse();
        run_cycles(40, 20, 30, 10, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined instruction-fetch stage sitting directly upstream of the IF/ID barrier.
- Owns the program counter and issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PCs and presents them to decode.
- Supports decode-side stall and branch/jump redirect with squash of in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, PC of the first fetch after reset.
- QUEUE_DEPTH, 2, instruction buffer entries; also the cap on outstanding plus buffered fetches (power of two, ≥2).
- NOP_INSTRUCTION, 32'h00000013, value driven on idInstruction when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imemReqValid  out  1  fetch request valid.
- imemReqReady  in  1  memory accepts request.
- imemReqAddr  out  32  fetch address, word aligned.
- imemRespValid  in  1  response data valid; responses return in request order, ≥1 cycle after acceptance.
- imemRespData  in  32  fetched instruction.
- stall  in  1  decode cannot consume this cycle.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirectPc  in  32  new PC; bits [1:0] ignored, treated as 00.
- idValid  out  1  idInstruction/idPc hold a real instruction.
- idInstruction  out  32  instruction to IF/ID barrier.
- idPc  out  32  PC of idInstruction.

Behaviour:
- State:
  - fetchPc (32b).
  - outstanding count, 0..QUEUE_DEPTH.
  - dropCount, 0..QUEUE_DEPTH.
  - FIFO of {pc, instruction}, QUEUE_DEPTH entries, with count.
  - Per-request PC tag queue, QUEUE_DEPTH entries.
- Reset values:
  - fetchPc=RESET_PC; outstanding=0; dropCount=0; FIFO empty; tag queue empty.
  - imemReqValid=0; idValid=0; idInstruction=NOP_INSTRUCTION; idPc=RESET_PC.
- Request:
  - imemReqValid = !reset && !redirect && (outstanding + fifoCount) < QUEUE_DEPTH.
  - imemReqAddr = fetchPc.
  - On accept (valid&&ready): push fetchPc to tag queue, fetchPc += 4 (wraps modulo 2^32), outstanding += 1.
  - While ready=0: valid and address stay stable.
- Response:
  - On imemRespValid: pop tag queue, outstanding -= 1.
  - If dropCount>0: discard the response and decrement dropCount.
  - Otherwise push {tag, imemRespData} into the FIFO.
  - The credit rule guarantees the FIFO is never full on a kept response.
  - Response and accept in the same cycle: the net outstanding change is 0.
- Decode output:
  - idValid = fifo non-empty.
  - idInstruction/idPc = head entry when non-empty, else NOP_INSTRUCTION and the last popped PC.
  - Pop when idValid && !stall && !redirect.
  - Latency is 1 cycle: a response kept at edge N is visible on id* after edge N.
  - Best-case throughput is one instruction per cycle with QUEUE_DEPTH≥2 and 1-cycle memory latency.
- Redirect (priority over stall):
  - In the redirect cycle, no request is issued and no pop occurs.
  - At the edge: FIFO and tag-queue contents are invalidated, except that tags for requests still outstanding remain consumable.
  - dropCount = outstanding after this cycle's response; a response arriving in the redirect cycle is itself discarded.
  - fetchPc = {redirectPc[31:2],2'b00}.
  - The first request to the new PC is issued the cycle after the redirect.
- Back-to-back redirects: the latest redirect wins, and dropCount accumulates to cover all in-flight requests.
- Stall with full buffer: imemReqValid drops; nothing is lost or duplicated.
- Reset asserted mid-operation: all state clears asynchronously. Instruction memory shares this reset and drops its in-flight responses.

Test Plan:
- Reset release, imemReqReady=1, memory latency 1 -> requests at 0,4,8,…; idValid rises 2 cycles after the first accept; idPc sequence 0,4,8 with matching data.
- Stream, then stall=1 for 3 cycles -> id* frozen at the same PC; at most QUEUE_DEPTH fetches are in flight or buffered; after release, PCs continue without gap or duplicate.
- imemReqReady=0 for 4 cycles at fetchPc=0x10 -> imemReqAddr held at 0x10, no accept; fetchPc still 0x10 after release.
- Two requests outstanding (0x20, 0x24) and redirect with redirectPc=0x103 -> both responses discarded; next request addr 0x100; first idValid instruction has idPc=0x100.
- Redirect in the same cycle as a response and with stall=1 -> the response is discarded, no pop, refetch from redirectPc.
- Reset pulse while the FIFO is full -> idValid=0, idInstruction=0x00000013, next request addr=RESET_PC.
